// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the CPU and the program loader.
// Round-robin arbitration with a loader burst lock; one fixed-latency registered access at a time.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_ack,
    output logic             cpu_err,
    output logic             cpu_stall,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic [WIDTH-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_wdata,
    output logic [WIDTH-1:0] ld_rdata,
    output logic             ld_ack,
    output logic             ld_err,
    input  logic             ld_lock,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state, state_nxt;
    logic             last_ld;     // last grant went to the loader
    logic             gnt_ld_q;    // current transaction belongs to the loader
    logic             we_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [CNT_W-1:0] cnt;

    logic             any_req, grant_ld, sel_we;
    logic [WIDTH-1:0] sel_addr, sel_wdata;

    // Tie goes to whoever did not win last time, unless the loader holds the lock.
    assign any_req   = cpu_req | ld_req;
    assign grant_ld  = ld_req & (~cpu_req | ~last_ld | ld_lock);
    assign sel_we    = grant_ld ? ld_we    : cpu_we;
    assign sel_addr  = grant_ld ? ld_addr  : cpu_addr;
    assign sel_wdata = grant_ld ? ld_wdata : cpu_wdata;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears state instantly, which also drops
    // the combinational memory strobes without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_ld  <= 1'b1;
            gnt_ld_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_ld_q <= grant_ld;
                        last_ld  <= grant_ld;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        cnt      <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = '0;
        ld_ack    = 1'b0;
        ld_err    = 1'b0;
        ld_rdata  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = (sel_addr[1:0] == 2'b00) ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                // Strobe only on the first access cycle so a write lands once.
                mem_we    = we_q & (cnt == CNT_INIT);
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (gnt_ld_q) begin
                    ld_ack   = 1'b1;
                    ld_rdata = rdata_q;
                end else begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = rdata_q;
                end
            end
            ERR: begin
                state_nxt = IDLE;
                if (gnt_ld_q) begin
                    ld_ack = 1'b1;
                    ld_err = 1'b1;
                end else begin
                    cpu_ack = 1'b1;
                    cpu_err = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus sequences for
// round-robin order, burst lock, protocol violations and mid-access reset.
module tb_mem_port_arbiter;

    localparam int WIDTH   = 32;
    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cpu_req = 1'b0, cpu_we = 1'b0;
    logic [WIDTH-1:0] cpu_addr = '0, cpu_wdata = '0;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_ack, cpu_err, cpu_stall;
    logic             ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
    logic [WIDTH-1:0] ld_addr = '0, ld_wdata = '0;
    logic [WIDTH-1:0] ld_rdata;
    logic             ld_ack, ld_err;
    logic             mem_en, mem_we;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack), .ld_err(ld_err), .ld_lock(ld_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Word-addressed memory model: combinational read, write on the clock edge.
    logic [31:0] mem [0:255];
    bit          mem_init = 1'b0;
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[4]   <= 32'hDEADBEEF;
            mem_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0; ld_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for either ack; lat is the edge count after the sampling edge, 0 on timeout.
    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ack || ld_ack) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        cpu_req, cpu_we;
        logic [31:0] cpu_addr, cpu_wdata;
        logic        ld_req, ld_we;
        logic [31:0] ld_addr, ld_wdata;
        logic        ld_lock;
        logic        exp_ld, exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_en, exp_we;
    } vec_t;

    function automatic vec_t mk(string name,
                                logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                                logic lr, logic lw, logic [31:0] la, logic [31:0] ldat,
                                logic lk, logic e_ld, logic e_err, logic [31:0] e_rd,
                                int e_lat, int e_en, int e_we);
        vec_t v;
        v.name = name;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
        v.ld_req = lr;  v.ld_we = lw;  v.ld_addr = la;  v.ld_wdata = ldat;
        v.ld_lock = lk; v.exp_ld = e_ld; v.exp_err = e_err; v.exp_rdata = e_rd;
        v.exp_lat = e_lat; v.exp_en = e_en; v.exp_we = e_we;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        int en_n = 0, we_n = 0, lat = 0;
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        ld_req  = v.ld_req;  ld_we  = v.ld_we;  ld_addr  = v.ld_addr;  ld_wdata  = v.ld_wdata;
        ld_lock = v.ld_lock;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (mem_en) en_n++;
            if (mem_we) we_n++;
            if (cpu_ack || ld_ack) begin
                lat = i;
                break;
            end
            if (i == 1) check({v.name, " stall"}, cpu_stall, v.cpu_req);
        end
        check({v.name, " latency"}, lat, v.exp_lat);
        check({v.name, " mem_en cycles"}, en_n, v.exp_en);
        check({v.name, " mem_we cycles"}, we_n, v.exp_we);
        check({v.name, " cpu_ack"}, cpu_ack, !v.exp_ld);
        check({v.name, " ld_ack"}, ld_ack, v.exp_ld);
        if (v.exp_ld) begin
            check({v.name, " ld_rdata"}, ld_rdata, v.exp_rdata);
            check({v.name, " ld_err"}, ld_err, v.exp_err);
            check({v.name, " cpu_rdata idle"}, cpu_rdata, 32'h0);
        end else begin
            check({v.name, " cpu_rdata"}, cpu_rdata, v.exp_rdata);
            check({v.name, " cpu_err"}, cpu_err, v.exp_err);
            check({v.name, " ld_rdata idle"}, ld_rdata, 32'h0);
        end
        check({v.name, " stall at ack"}, cpu_stall, v.cpu_req & v.exp_ld);
        idle_inputs();
        @(posedge clk); @(negedge clk);
        check({v.name, " ack one cycle"}, {cpu_ack, ld_ack}, 2'b00);
    endtask

    // Both requesters held; lock (if any) is raised after the first grant is made.
    task automatic rr_seq(input string tag, input logic lock, input int n,
                          input logic [7:0] exp_ld, input int drop_lock_after);
        int acks = 0, cyc = 0, prev = 0;
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h10;
        ld_req  = 1'b1; ld_addr  = 32'h40;
        while (acks < n && cyc < 100) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (cyc == 1) ld_lock = lock;
            if (cpu_ack || ld_ack) begin
                check($sformatf("%s txn%0d ld_ack", tag, acks), ld_ack, exp_ld[acks]);
                check($sformatf("%s txn%0d cpu_ack", tag, acks), cpu_ack, !exp_ld[acks]);
                if (acks > 0) check($sformatf("%s txn%0d spacing", tag, acks), cyc - prev, MEM_LAT + 2);
                prev = cyc;
                acks++;
                if (acks == drop_lock_after) ld_lock = 1'b0;
            end
        end
        check({tag, " ack count"}, acks, n);
        idle_inputs();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int lat;

        // Reset state
        @(negedge clk);
        check("reset cpu_ack", cpu_ack, 1'b0);
        check("reset ld_ack", ld_ack, 1'b0);
        check("reset mem_en", mem_en, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset cpu_stall", cpu_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        //          name          cr cw cpu_addr      cpu_wdata     lr lw ld_addr       ld_wdata      lk  eld err rdata         lat en we
        vecs.push_back(mk("cpu rd 10",   1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        0,  0, 0, 32'hDEADBEEF, 3, 2, 0));
        vecs.push_back(mk("ld wr 40",    0, 0, 32'h0,  32'h0,        1, 1, 32'h40, 32'h12345678, 0,  1, 0, 32'h0,        3, 2, 1));
        vecs.push_back(mk("cpu rd 40",   1, 0, 32'h40, 32'h0,        0, 0, 32'h0,  32'h0,        0,  0, 0, 32'h12345678, 3, 2, 0));
        vecs.push_back(mk("cpu misalign",1, 0, 32'h13, 32'h0,        0, 0, 32'h0,  32'h0,        0,  0, 1, 32'h0,        1, 0, 0));
        vecs.push_back(mk("tie ld turn", 1, 0, 32'h10, 32'h0,        1, 0, 32'h40, 32'h0,        0,  1, 0, 32'h12345678, 3, 2, 0));
        vecs.push_back(mk("tie cpu turn",1, 0, 32'h10, 32'h0,        1, 0, 32'h40, 32'h0,        0,  0, 0, 32'hDEADBEEF, 3, 2, 0));
        vecs.push_back(mk("lock ld turn",1, 0, 32'h10, 32'h0,        1, 0, 32'h40, 32'h0,        1,  1, 0, 32'h12345678, 3, 2, 0));
        vecs.push_back(mk("lock override",1,0, 32'h10, 32'h0,        1, 0, 32'h40, 32'h0,        1,  1, 0, 32'h12345678, 3, 2, 0));
        vecs.push_back(mk("lock no ldreq",1,0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        1,  0, 0, 32'hDEADBEEF, 3, 2, 0));
        vecs.push_back(mk("ld misalign", 0, 0, 32'h0,  32'h0,        1, 1, 32'h42, 32'hFFFFFFFF, 0,  1, 1, 32'h0,        1, 0, 0));
        vecs.push_back(mk("cpu wr 80",   1, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 32'h0,  32'h0,        0,  0, 0, 32'h0,        3, 2, 1));
        vecs.push_back(mk("ld rd 80",    0, 0, 32'h0,  32'h0,        1, 0, 32'h80, 32'h0,        0,  1, 0, 32'hA5A5A5A5, 3, 2, 0));
        vecs.push_back(mk("cpu rd 40 b", 1, 0, 32'h40, 32'h0,        0, 0, 32'h0,  32'h0,        0,  0, 0, 32'h12345678, 3, 2, 0));

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

        // Round-robin from reset, then burst lock released after the fourth grant
        rr_seq("rr", 1'b0, 4, 8'b0000_1010, 99);
        rr_seq("lock", 1'b1, 5, 8'b0000_1110, 4);

        // Request dropped and payload changed after grant: original access still completes
        cpu_req = 1'b1; cpu_addr = 32'h10;
        @(posedge clk); @(negedge clk);
        cpu_req = 1'b0; cpu_addr = 32'h40;
        wait_ack(10, lat);
        check("drop req latency", lat, MEM_LAT);
        check("drop req cpu_ack", cpu_ack, 1'b1);
        check("drop req cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("drop req stall", cpu_stall, 1'b0);
        idle_inputs();
        @(posedge clk); @(negedge clk);

        // Reset in the middle of a loader write
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'hC0; ld_wdata = 32'h55AA55AA;
        @(posedge clk); @(negedge clk);
        check("midrst mem_we before", mem_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst mem_en async", mem_en, 1'b0);
        check("midrst mem_we async", mem_we, 1'b0);
        idle_inputs();
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ld_ack) lat++;
        end
        check("midrst no ld_ack", lat, 0);
        rst = 1'b0;
        check("midrst no write", mem[48], 32'h0);
        cpu_req = 1'b1; cpu_addr = 32'h10;
        ld_req  = 1'b1; ld_addr  = 32'h40;
        wait_ack(10, lat);
        check("post rst latency", lat, MEM_LAT + 1);
        check("post rst cpu wins", cpu_ack, 1'b1);
        check("post rst cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        idle_inputs();
        @(posedge clk); @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU (fetch/load/store) and the program loader (boot/debug writes).
- Each access is one registered, fixed-latency transaction.
- Fairness is round-robin; the loader can lock the port for bursts.
- Provides `cpu_stall` so the control FSM can hold its state while waiting on memory.

Parameters:
- WIDTH, 32, data and address width in bits
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15
- CNT_W, 4, width of the internal latency counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  WIDTH  byte address; must be word-aligned
- cpu_wdata  in  WIDTH  write data
- cpu_rdata  out  WIDTH  read data; valid only while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned access flag; valid with cpu_ack
- cpu_stall  out  1  cpu_req & ~cpu_ack
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ack, ld_err  same as cpu_* for the loader
- ld_lock  in  1  loader burst lock
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data; valid MEM_LAT cycles after the first mem_en cycle

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - state=IDLE, last_grant=LD (so the CPU wins the first tie), counter=0.
  - All outputs 0; mem_en and mem_we drop immediately.
  - Any in-flight transaction is abandoned with no ack.
- IDLE:
  - If any req=1, register the winner's id, addr, we, wdata.
  - Aligned (addr[1:0]==0): go to ACCESS with counter=MEM_LAT-1.
  - Misaligned: go to ERR; no memory activity.
  - No req: stay in IDLE.
- Arbitration, evaluated in IDLE only:
  - Single requester wins.
  - Both requesting: grant the one that is not last_grant.
  - Override: if ld_lock=1 and last_grant=LD, the loader wins.
  - last_grant updates on every grant.
- ACCESS:
  - mem_en=1; mem_addr/mem_wdata driven from registers.
  - mem_we=we_q on the first ACCESS cycle only, so a write hits memory exactly once.
  - Counter decrements each cycle. At counter==0, capture mem_rdata into rdata_q (zero for writes) and go to RESP.
  - ACCESS lasts exactly MEM_LAT cycles.
- RESP (1 cycle):
  - Winner's ack=1, rdata=rdata_q, err=0. The other requester's ack, rdata and err stay 0.
  - Next state IDLE.
- ERR (1 cycle):
  - Winner's ack=1, err=1, rdata=0.
  - Next state IDLE.
- Latency: for a request first sampled at edge E, ack is high in cycle E+MEM_LAT+1 (E+1 for misaligned).
- Back-to-back: there is one IDLE cycle between transactions, so throughput is one access per MEM_LAT+2 cycles.
- Handshake rules:
  - A requester must keep req and payload stable until it sees ack.
  - req still high in the cycle after ack is treated as a new request.
  - Payload changes while req=1 and before ack are ignored, because the payload is registered at grant.
- req dropping mid-transaction (protocol violation): the transaction still completes and ack still pulses.
- cpu_stall is combinational: cpu_req & ~cpu_ack. It is 0 whenever cpu_req=0.
- ld_lock behaviour:
  - Asserting ld_lock while the CPU holds the port takes effect only at the next IDLE arbitration.
  - ld_lock=1 with ld_req=0 does not block the CPU.

Test Plan:
- Reset, then CPU read: cpu_req=1, cpu_addr=0x00000010, mem model returns 0xDEADBEEF with MEM_LAT=2 → mem_en high for exactly 2 cycles; cpu_ack high 3 cycles after the sampling edge with cpu_rdata=0xDEADBEEF; cpu_stall=1 until ack.
- Loader write: ld_we=1, ld_addr=0x40, ld_wdata=0x12345678 → mem_we high for exactly 1 cycle with those values; ld_ack pulses; a subsequent CPU read of 0x40 returns 0x12345678.
- Simultaneous requests from reset, both held for 4 transactions with ld_lock=0 → grant order CPU, LD, CPU, LD; exactly one ack per transaction.
- Same stimulus with ld_lock=1 → order CPU, LD, LD, LD; CPU is served once ld_lock drops or ld_req drops.
- Misaligned: cpu_addr=0x00000013 → no mem_en; next cycle cpu_ack=1, cpu_err=1, cpu_rdata=0.
- Assert rst during ACCESS of a loader write → mem_en/mem_we go to 0 without waiting for a clock edge; no ld_ack; after release, a fresh CPU request completes normally and the CPU wins a tie.
